lector_destinos: RTL
====================

Name: lector_destinos

Overview:
- Drain stage directly downstream of the D0/D1 destination FIFOs of the QoS interconnect.
- Pops both FIFOs under round-robin arbitration and merges them into one output stream with valid/ready backpressure.
- Per-source word counters and an idle flag feed the bench checker and the state-machine status logic.

Parameters:
BW, 6, data word width (matches the D0/D1 FIFO width)
CW, 8, width of each per-source word counter

Ports:
clk  input  1  system clock, all state on rising edge
reset_L  input  1  reset, asynchronous, active-low
init  input  1  enable; 0 blocks new FIFO reads
D0_empty  input  1  D0 FIFO empty flag
D1_empty  input  1  D1 FIFO empty flag
D0_error_output  input  1  D0 FIFO error; masks D0 from arbitration
D1_error_output  input  1  D1 FIFO error; masks D1 from arbitration
D0_data_out  input  BW  D0 FIFO read data, valid the cycle after D0_rd
D1_data_out  input  BW  D1 FIFO read data, valid the cycle after D1_rd
D0_rd  output  1  pop request to D0 FIFO
D1_rd  output  1  pop request to D1 FIFO
out_ready  input  1  downstream accepts word when out_valid=1
out_valid  output  1  out_data/out_src hold a valid word
out_data  output  BW  merged data word
out_src  output  1  source of out_data (0=D0, 1=D1)
cnt_D0  output  CW  words from D0 accepted downstream
cnt_D1  output  CW  words from D1 accepted downstream
idle  output  1  no work pending or in flight

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, reset_L).
- Reset, asynchronous on reset_L=0:
  - Outputs: D0_rd=0, D1_rd=0, out_valid=0, out_data=0, out_src=0, cnt_D0=0, cnt_D1=0, idle=0.
  - Internal state: queue empty, in-flight flag cleared, RR pointer=D1 so D0 wins the first tie.
  - Reset mid-operation drops any in-flight read and all queued words.
- Output buffer: 2-entry FIFO of {src, data}.
  - out_valid = (occupancy != 0); out_data/out_src come from the head entry.
  - The head pops on out_valid & out_ready.
  - Output holds stable while out_valid=1 and out_ready=0.
- In-flight: registered flag inflight = (D0_rd|D1_rd) of the previous cycle, plus registered inflight_src.
- Credit:
  - credit = occupancy + inflight - (out_valid & out_ready).
  - A read may issue only when credit < 2, so the queue never overflows.
- Eligibility: Dx is eligible when init=1, Dx_empty=0 and Dx_error_output=0.
- Arbitration, combinational D0_rd/D1_rd:
  - At most one asserted per cycle.
  - Both eligible: grant the source not granted last.
  - One eligible: grant it.
  - The RR pointer updates only on a grant.
- Latency:
  - rd asserted in cycle N.
  - Dx_data_out sampled at the end of cycle N+1 and written to the queue.
  - out_valid=1 in cycle N+2 if the queue was empty.
- Throughput: with out_ready held at 1, 1 word/cycle sustained.
- Simultaneous write and pop on the queue: both occur; occupancy is unchanged.
- Empty flags: rd is never issued while Dx_empty=1. The FIFO empty flag is registered and reflects the prior pop by the next cycle.
- init 1->0: no new reads; an in-flight word is still captured and the queue drains normally.
- Error flag rising while a read is in flight: that word is still captured.
- Counters:
  - cnt_D0/cnt_D1 increment on each accepted output word (out_valid & out_ready) per out_src.
  - They wrap modulo 2^CW (255 -> 0 at CW=8).
  - Cleared only by reset.
- idle=1 when init=1, occupancy=0, inflight=0, and no source is eligible.

Test Plan:
- Reset, then init=1 with D0 holding 3 words (0x01,0x17,0x0C) and D1 empty, out_ready=1 -> D0_rd high 3 consecutive cycles; out stream 0x01,0x17,0x0C with out_src=0; cnt_D0=3; idle=1 afterwards.
- Both FIFOs with 4 words each, out_ready=1 -> D0_rd/D1_rd strictly alternate starting with D0; out_src sequence 0,1,0,1,...; cnt_D0=cnt_D1=4.
- Backpressure: out_ready=0 with both FIFOs non-empty -> exactly 2 reads issued, then rd stays 0; out_data stable; after out_ready=1 all words appear in order with no loss or duplication.
- D1_error_output=1 while both non-empty -> only D0_rd ever asserts; D1 words untouched; clearing the error resumes alternation.
- Assert reset_L=0 mid-stream with a read in flight -> all outputs return to reset values immediately (async); after release no stale word appears on out_data.
- Push 256 D0 words through -> cnt_D0 wraps to 0 on the 256th accepted word.

Source files
------------

// File: rtl/lector_destinos.sv
// Drain stage for the D0/D1 destination FIFOs: round-robin pop,
// 2-entry skid queue, merged valid/ready output with per-source counters.
module lector_destinos #(
    parameter int BW = 6,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset_L,
    input  logic          init,
    input  logic          D0_empty,
    input  logic          D1_empty,
    input  logic          D0_error_output,
    input  logic          D1_error_output,
    input  logic [BW-1:0] D0_data_out,
    input  logic [BW-1:0] D1_data_out,
    output logic          D0_rd,
    output logic          D1_rd,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [BW-1:0] out_data,
    output logic          out_src,
    output logic [CW-1:0] cnt_D0,
    output logic [CW-1:0] cnt_D1,
    output logic          idle
);

    logic [BW:0]   mem_q [2];
    logic [BW:0]   mem_d [2];
    logic          wp_q, wp_d;
    logic          rp_q, rp_d;
    logic [1:0]    occ_q, occ_d;
    logic          inflight_q, inflight_d;
    logic          inflight_src_q, inflight_src_d;
    logic          rr_q, rr_d;
    logic [CW-1:0] cnt0_q, cnt0_d;
    logic [CW-1:0] cnt1_q, cnt1_d;

    logic          pop;
    logic          elig0, elig1;
    logic          can_issue;
    logic [2:0]    credit;
    logic [BW-1:0] wdata;

    always_comb begin
        out_valid = (occ_q != 2'd0);
        out_data  = mem_q[rp_q][BW-1:0];
        out_src   = mem_q[rp_q][BW];
        pop       = out_valid & out_ready;

        credit    = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
        can_issue = (credit < 3'd2);

        elig0 = init & ~D0_empty & ~D0_error_output;
        elig1 = init & ~D1_empty & ~D1_error_output;

        D0_rd = 1'b0;
        D1_rd = 1'b0;
        if (reset_L && can_issue) begin
            // rr_q holds the last granted source; a tie goes to the other one
            if (elig0 && elig1) begin
                D0_rd = rr_q;
                D1_rd = ~rr_q;
            end else begin
                D0_rd = elig0;
                D1_rd = elig1;
            end
        end

        rr_d = rr_q;
        if (D1_rd) begin
            rr_d = 1'b1;
        end else if (D0_rd) begin
            rr_d = 1'b0;
        end

        inflight_d     = D0_rd | D1_rd;
        inflight_src_d = D1_rd;

        wdata = inflight_src_q ? D1_data_out : D0_data_out;
        mem_d = mem_q;
        if (inflight_q) begin
            mem_d[wp_q] = {inflight_src_q, wdata};
        end
        wp_d  = wp_q ^ inflight_q;
        rp_d  = rp_q ^ pop;
        occ_d = occ_q + {1'b0, inflight_q} - {1'b0, pop};

        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (pop && !out_src) begin
            cnt0_d = cnt0_q + 1'b1;
        end
        if (pop && out_src) begin
            cnt1_d = cnt1_q + 1'b1;
        end

        cnt_D0 = cnt0_q;
        cnt_D1 = cnt1_q;
        idle   = reset_L & init & (occ_q == 2'd0) & ~inflight_q
               & ~elig0 & ~elig1;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            wp_q           <= 1'b0;
            rp_q           <= 1'b0;
            occ_q          <= 2'd0;
            inflight_q     <= 1'b0;
            inflight_src_q <= 1'b0;
            rr_q           <= 1'b1;
            cnt0_q         <= '0;
            cnt1_q         <= '0;
        end else begin
            mem_q          <= mem_d;
            wp_q           <= wp_d;
            rp_q           <= rp_d;
            occ_q          <= occ_d;
            inflight_q     <= inflight_d;
            inflight_src_q <= inflight_src_d;
            rr_q           <= rr_d;
            cnt0_q         <= cnt0_d;
            cnt1_q         <= cnt1_d;
        end
    end

endmodule
